temp_input_conditioner: RTL and testbench
=========================================

# temp_input_conditioner

Upstream front end of the temperature monitor. Takes the raw slide-switch temperature word and the raw sign-mode key, then synchronizes and debounces both. It clamps the fractional digit, averages the last 2^AVG_LOG2 samples on each 1 Hz tick, and delivers `temp`/`temp_frac`/`mode` plus a one-cycle `sample_valid` strobe to the monitor and BCD stages.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable clk cycles required before a synchronized input is accepted (10 ms at 50 MHz).
- AVG_LOG2, 2: log2 of the moving-average depth; 2 gives 4 samples.

- clk  in  1  system clock (CLOCK_50).
- rst  in  1  reset; one clock, reset is asynchronous and active-high.
- tick  in  1  sample enable; one clk wide, nominally 1 Hz.
- sw_raw  in  10  raw switches; [9:4] integer degrees, [3:0] tenths.
- key_mode_n  in  1  raw sign-mode key, active-low.
- temp  out  6  averaged integer degrees, 0..63.
- temp_frac  out  4  averaged tenths, 0..9.
- mode  out  1  sign mode; 0 = positive, 1 = negative.
- sample_valid  out  1  one-cycle pulse when `temp`/`temp_frac` update.

## Operation
- Synchronization: two-flop synchronizer on all of `sw_raw` and on `key_mode_n`.
- Debounce, switches:
  - Any change of the synchronized word vs the candidate reloads the candidate and clears the counter.
  - After DEBOUNCE_CYCLES stable cycles the candidate is copied to `sw_db`.
- Debounce, key: a separate, identical debouncer on the key produces `key_db`.
- Mode:
  - Toggles on each debounced 1->0 transition of `key_db`, independent of `tick`.
  - Release never toggles. One press gives exactly one toggle.
- Conversion: v = sw_db[9:4]*10 + min(sw_db[3:0], 9). v is 10 bits, 0..639.
- History:
  - Shift register of 2^AVG_LOG2 entries, each 10 bits.
  - Running sum is 10+AVG_LOG2 bits, updated as sum + v - oldest.
  - First accepted tick after reset (primed=0) fills every entry with v, sets sum = v<<AVG_LOG2, and sets primed=1.
- Average: avg = sum >> AVG_LOG2, truncating.
- FSM states IDLE, ACCUM, DIV:
  - IDLE, tick=1: update history/sum, go to ACCUM.
  - ACCUM: rem <= avg, quo <= 0, go to DIV.
  - DIV, rem >= 10: rem <= rem-10, quo <= quo+1, stay in DIV.
  - DIV, rem < 10: temp <= quo, temp_frac <= rem, sample_valid <= 1, go to IDLE.
- Ticks arriving outside IDLE are dropped; history is not updated.
- Reset values:
  - temp=0, temp_frac=0, mode=0, sample_valid=0.
  - sw_db=0, key_db=1, history=0, sum=0, primed=0, state=IDLE, debounce counters=0.
- Reset asserted mid-operation: every register takes its reset value immediately; no `sample_valid` is issued for the aborted sample.

## Timing
- Tick sampled at edge k:
  - history updated at k+1;
  - rem loaded at k+2;
  - q = floor(avg/10) subtract cycles;
  - outputs and `sample_valid` high in the cycle after edge k+3+q.
- Latency is 3+q cycles. Minimum 3 (avg < 10); maximum 66 (avg 639).
- `sample_valid` is high for exactly one cycle. `temp`/`temp_frac` hold until the next valid.
- Input to `sw_db` latency is 2 sync cycles + DEBOUNCE_CYCLES.
- `mode` changes one cycle after `key_db` falls.
- A tick at the same edge as a `sw_db` update uses the old `sw_db`.

## Test plan
- Test parameters: DEBOUNCE_CYCLES=8, AVG_LOG2=2.
- Prime: after reset, sw_raw=0x1A5 (26.5) held stable, then tick -> `sample_valid` 29 cycles later, temp=26, temp_frac=5.
- Clamp and maximum: sw_raw=0x3FF, tick -> temp=63, temp_frac=9, latency 66 cycles. sw_raw=0x0AF -> temp=10, temp_frac=9.
- Average: primed at 10.0, switch to 20.0, debounce, tick -> temp=12, temp_frac=5. Three more ticks -> 15.0, 17.5, 20.0.
- Bounce: sw_raw toggles every 2 cycles for 20 cycles, then settles at 0x140 -> `sw_db` changes only 10 cycles after the last edge. Ticks during bouncing report the old value.
- Key: bounced press (5 glitches) then bounced release -> `mode` 0->1 exactly once. Second press -> 1->0.
- Reset mid-DIV: sw_raw=0x3FF, assert rst 10 cycles after tick -> all outputs 0, no `sample_valid`. Next tick re-primes from the current switches.

Source files
------------

// File: rtl/temp_input_conditioner.sv
// Temperature front end: synchronizes and debounces the switch word and the
// sign-mode key, converts the switches to tenths of a degree, keeps a
// power-of-two moving average updated on each sample tick, and splits the
// average back into degrees/tenths with a small repeated-subtraction divider.
module temp_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AVG_LOG2        = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [9:0] sw_raw,
  input  logic       key_mode_n,
  output logic [5:0] temp,
  output logic [3:0] temp_frac,
  output logic       mode,
  output logic       sample_valid
);

  localparam int CW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUMW  = 10 + AVG_LOG2;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE, ACCUM, DIV} state_t;

  // ---------------- switch path ----------------
  logic [9:0]    sw_s1_q, sw_s2_q, sw_cand_q, sw_db_q;
  logic [CW-1:0] sw_cnt_q;

  // Two-flop sync, then accept the candidate once it has been stable long enough.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      sw_cand_q <= '0;
      sw_cnt_q  <= '0;
      sw_db_q   <= '0;
    end else begin
      sw_s1_q <= sw_raw;
      sw_s2_q <= sw_s1_q;
      if (sw_s2_q != sw_cand_q) begin
        sw_cand_q <= sw_s2_q;
        sw_cnt_q  <= '0;
      end else begin
        if (sw_cnt_q == CNT_LAST) sw_db_q <= sw_cand_q;
        if (sw_cnt_q != CNT_MAX)  sw_cnt_q <= sw_cnt_q + 1'b1;
      end
    end
  end

  // ---------------- key path ----------------
  logic          key_s1_q, key_s2_q, key_cand_q, key_db_q, key_prev_q, mode_q;
  logic [CW-1:0] key_cnt_q;

  // Same debouncer for the key (idle high); mode flips on each debounced press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1_q   <= 1'b1;
      key_s2_q   <= 1'b1;
      key_cand_q <= 1'b1;
      key_cnt_q  <= '0;
      key_db_q   <= 1'b1;
      key_prev_q <= 1'b1;
      mode_q     <= 1'b0;
    end else begin
      key_s1_q   <= key_mode_n;
      key_s2_q   <= key_s1_q;
      key_prev_q <= key_db_q;
      if (key_s2_q != key_cand_q) begin
        key_cand_q <= key_s2_q;
        key_cnt_q  <= '0;
      end else begin
        if (key_cnt_q == CNT_LAST) key_db_q <= key_cand_q;
        if (key_cnt_q != CNT_MAX)  key_cnt_q <= key_cnt_q + 1'b1;
      end
      if (key_prev_q && !key_db_q) mode_q <= ~mode_q;
    end
  end

  // ---------------- tick capture ----------------
  // The tick and the converted value are captured together, so a tick that
  // coincides with a sw_db update still sees the old switch word.
  logic [3:0] frac_clamp;
  logic [9:0] v_d, v_q;
  logic       tick_q;

  // Tenths value of the debounced switches, fraction digit clamped to 9.
  always_comb begin
    frac_clamp = (sw_db_q[3:0] > 4'd9) ? 4'd9 : sw_db_q[3:0];
    v_d        = 10'(sw_db_q[9:4]) * 10'd10 + 10'(frac_clamp);
  end

  // Sample register for the tick and its value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= 1'b0;
      v_q    <= '0;
    end else begin
      tick_q <= tick;
      v_q    <= v_d;
    end
  end

  // ---------------- averaging FSM ----------------
  state_t                  state_q, state_d;
  logic [DEPTH-1:0][9:0]   hist_q, hist_d;
  logic [SUMW-1:0]         sum_q, sum_d, avg_w;
  logic                    primed_q, primed_d;
  logic [9:0]              rem_q, rem_d;
  logic [5:0]              quo_q, quo_d, temp_q, temp_d;
  logic [3:0]              frac_q, frac_d;
  logic                    valid_q, valid_d;

  assign avg_w = sum_q >> AVG_LOG2;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; ticks outside IDLE are simply ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick_q) state_d = ACCUM;
      ACCUM:   state_d = DIV;
      DIV:     if (rem_q < 10'd10) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: history/sum update, divide by ten, result publish.
  always_comb begin
    hist_d   = hist_q;
    sum_d    = sum_q;
    primed_d = primed_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    temp_d   = temp_q;
    frac_d   = frac_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: if (tick_q) begin
        if (!primed_q) begin
          // First sample fills the whole window so the average starts settled.
          for (int i = 0; i < DEPTH; i++) hist_d[i] = v_q;
          sum_d    = SUMW'(v_q) << AVG_LOG2;
          primed_d = 1'b1;
        end else begin
          hist_d[0] = v_q;
          for (int i = 1; i < DEPTH; i++) hist_d[i] = hist_q[i-1];
          sum_d = sum_q + SUMW'(v_q) - SUMW'(hist_q[DEPTH-1]);
        end
      end
      ACCUM: begin
        rem_d = avg_w[9:0];
        quo_d = '0;
      end
      DIV: begin
        if (rem_q >= 10'd10) begin
          rem_d = rem_q - 10'd10;
          quo_d = quo_q + 6'd1;
        end else begin
          temp_d  = quo_q;
          frac_d  = rem_q[3:0];
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q   <= '0;
      sum_q    <= '0;
      primed_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      temp_q   <= '0;
      frac_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      sum_q    <= sum_d;
      primed_q <= primed_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      temp_q   <= temp_d;
      frac_q   <= frac_d;
      valid_q  <= valid_d;
    end
  end

  assign temp         = temp_q;
  assign temp_frac    = frac_q;
  assign mode         = mode_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_temp_input_conditioner.sv
// Bench for temp_input_conditioner: directed scenarios plus random switch
// words, each result compared with a queue-based moving-average model.
module tb_temp_input_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [9:0] sw_raw = '0;
  logic       key_mode_n = 1'b1;
  logic [5:0] temp;
  logic [3:0] temp_frac;
  logic       mode;
  logic       sample_valid;

  temp_input_conditioner #(.DEBOUNCE_CYCLES(8), .AVG_LOG2(2)) dut (
    .clk(clk), .rst(rst), .tick(tick), .sw_raw(sw_raw), .key_mode_n(key_mode_n),
    .temp(temp), .temp_frac(temp_frac), .mode(mode), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model of the switch word the design has accepted: a value counts once it
  // has been held well past the debounce window. Ticks are only issued far
  // from the acceptance edge, so the exact cycle does not matter.
  logic [9:0] sw_prev, sw_acc;
  int         run;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_prev <= '0;
      sw_acc  <= '0;
      run     <= 0;
    end else begin
      sw_prev <= sw_raw;
      if (sw_raw != sw_prev) run <= 0;
      else if (run < 1000)   run <= run + 1;
      if (run >= 11) sw_acc <= sw_prev;
    end
  end

  // Count mode changes to prove one press toggles exactly once.
  logic mode_prev = 1'b0;
  int   mode_chg = 0;
  always @(posedge clk) begin
    mode_prev <= mode;
    if (!rst && mode != mode_prev) mode_chg <= mode_chg + 1;
  end

  // Moving-average reference.
  int hist[$];
  bit primed = 0;
  int exp_t, exp_f, exp_lat;

  task automatic model_reset();
    hist.delete();
    primed = 0;
  endtask

  task automatic model_tick(input logic [9:0] sw);
    int v, sum, avg, fr;
    fr = int'(sw[3:0]);
    if (fr > 9) fr = 9;
    v = int'(sw[9:4]) * 10 + fr;
    if (!primed) begin
      hist = '{v, v, v, v};
      primed = 1;
    end else begin
      hist.push_front(v);
      void'(hist.pop_back());
    end
    sum = 0;
    foreach (hist[i]) sum += hist[i];
    avg = sum / 4;
    exp_t = avg / 10;
    exp_f = avg % 10;
    exp_lat = 3 + avg / 10;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One tick; optionally fire a second tick mid-divide, which must be dropped.
  task automatic do_tick(input string tag, input bit inj);
    int n;
    bit got;
    @(posedge clk); #1;
    model_tick(sw_acc);
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    n = 0;
    got = 0;
    while (!got && n < 100) begin
      @(posedge clk); #1;
      n++;
      tick = (inj && exp_lat > 8 && n == 5);
      if (sample_valid) got = 1;
    end
    tick = 1'b0;
    chk({tag, "_valid_seen"}, int'(got), 1);
    if (got) begin
      chk({tag, "_latency"}, n, exp_lat);
      chk({tag, "_temp"}, int'(temp), exp_t);
      chk({tag, "_frac"}, int'(temp_frac), exp_f);
      wait_cyc(1);
      chk({tag, "_valid_one_cycle"}, int'(sample_valid), 0);
      chk({tag, "_temp_hold"}, int'(temp), exp_t);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    model_reset();
    wait_cyc(1);
  endtask

  initial begin
    int c0, pulses;
    wait_cyc(2);
    chk("rst_temp", int'(temp), 0);
    chk("rst_frac", int'(temp_frac), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_valid", int'(sample_valid), 0);
    rst = 1'b0;
    wait_cyc(1);

    // Prime at 26.5: latency 29, result 26.5
    sw_raw = 10'h1A5; wait_cyc(15);
    do_tick("prime", 0);
    chk("prime_abs_temp", int'(temp), 26);
    chk("prime_abs_frac", int'(temp_frac), 5);

    // Clamp and maximum
    do_reset();
    sw_raw = 10'h3FF; wait_cyc(15);
    do_tick("max", 0);
    chk("max_abs_temp", int'(temp), 63);
    chk("max_abs_frac", int'(temp_frac), 9);
    do_reset();
    sw_raw = 10'h0AF; wait_cyc(15);
    do_tick("clamp", 0);
    chk("clamp_abs_temp", int'(temp), 10);
    chk("clamp_abs_frac", int'(temp_frac), 9);

    // Average ramp 10.0 -> 20.0
    do_reset();
    sw_raw = 10'h0A0; wait_cyc(15);
    do_tick("avg0", 0);
    sw_raw = 10'h140; wait_cyc(15);
    do_tick("avg1", 0);
    chk("avg1_abs", int'(temp) * 10 + int'(temp_frac), 125);
    do_tick("avg2", 1);
    chk("avg2_abs", int'(temp) * 10 + int'(temp_frac), 150);
    do_tick("avg3", 0);
    chk("avg3_abs", int'(temp) * 10 + int'(temp_frac), 175);
    do_tick("avg4", 0);
    chk("avg4_abs", int'(temp) * 10 + int'(temp_frac), 200);

    // Bounce: ticks while bouncing and just after settling see the old word
    do_reset();
    sw_raw = 10'h0A0; wait_cyc(15);
    do_tick("bnc_prime", 0);
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          sw_raw = (i % 2 == 0) ? 10'h140 : 10'h0A0;
          wait_cyc(2);
        end
      end
      begin
        wait_cyc(6);
        do_tick("bnc_during", 0);
      end
    join
    chk("bnc_during_abs", int'(temp) * 10 + int'(temp_frac), 100);
    sw_raw = 10'h140; wait_cyc(8);
    do_tick("bnc_early", 0);
    chk("bnc_early_abs", int'(temp) * 10 + int'(temp_frac), 100);
    wait_cyc(15);
    do_tick("bnc_settled", 0);
    chk("bnc_settled_abs", int'(temp) * 10 + int'(temp_frac), 125);

    // Key: bounced press and release toggle once; second press toggles back
    c0 = mode_chg;
    for (int i = 0; i < 5; i++) begin
      key_mode_n = 1'b0; wait_cyc(2);
      key_mode_n = 1'b1; wait_cyc(2);
    end
    key_mode_n = 1'b0; wait_cyc(20);
    chk("key_press_mode", int'(mode), 1);
    for (int i = 0; i < 5; i++) begin
      key_mode_n = 1'b1; wait_cyc(2);
      key_mode_n = 1'b0; wait_cyc(2);
    end
    key_mode_n = 1'b1; wait_cyc(20);
    chk("key_release_mode", int'(mode), 1);
    chk("key_toggle_count", mode_chg - c0, 1);
    key_mode_n = 1'b0; wait_cyc(20);
    chk("key_press2_mode", int'(mode), 0);
    key_mode_n = 1'b1; wait_cyc(20);
    chk("key_toggle_count2", mode_chg - c0, 2);

    // Reset in the middle of the divide
    sw_raw = 10'h3FF; wait_cyc(15);
    tick = 1'b1; wait_cyc(1); tick = 1'b0;
    wait_cyc(10);
    rst = 1'b1; #1;
    chk("rstmid_temp", int'(temp), 0);
    chk("rstmid_frac", int'(temp_frac), 0);
    chk("rstmid_mode", int'(mode), 0);
    chk("rstmid_valid", int'(sample_valid), 0);
    wait_cyc(2);
    rst = 1'b0;
    model_reset();
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      wait_cyc(1);
      if (sample_valid) pulses++;
    end
    chk("rstmid_no_valid", pulses, 0);
    do_tick("reprime", 0);
    chk("reprime_abs", int'(temp) * 10 + int'(temp_frac), 639);

    // Random switch words, some with a dropped mid-divide tick
    for (int i = 0; i < 12; i++) begin
      sw_raw = 10'($urandom_range(0, 1023));
      wait_cyc($urandom_range(14, 20));
      do_tick("rand", bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
